// File: rtl/moonbase_bus_pkg.sv
// Shared definitions for the moonbase multiplexed nibble bus responder.
// Contents:
//   - bit positions inside the CPU io_out byte
//   - write/address FSM state encoding
//   - address and address-half widths
package moonbase_bus_pkg;

    // io_out bit positions
    localparam int STB    = 7;  // 1 = address strobe cycle
    localparam int NIB    = 6;  // 0 = high nibble / low address half, 1 = low nibble / high half
    localparam int WRAM_N = 5;  // active-low RAM write (data cycles only)
    localparam int WDEV_N = 4;  // active-low device write (data cycles only)

    localparam int ADDR_W = 12;
    localparam int HALF_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADR_LO = 2'd1,  // previous cycle was a low-half address strobe
        ST_WR_HI  = 2'd2   // high nibble of a write is held, waiting for the low nibble
    } bus_state_e;

endpackage

// File: rtl/moonbase_byte_ram.sv
// Byte memory behind the nibble bus.
// Ports:
//   clk                      clock
//   cpu_we_i/addr_i/wdata_i  CPU-side write request
//   ld_en_i/addr_i/data_i    loader write; wins over a same-cycle CPU write
//   rd_addr_i, rd_data_o     asynchronous read port
module moonbase_byte_ram #(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 cpu_we_i,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic [7:0]           cpu_wdata_i,
    input  logic                 ld_en_i,
    input  logic [ADDR_BITS-1:0] ld_addr_i,
    input  logic [7:0]           ld_data_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [7:0]           rd_data_o
);

    logic [7:0] mem_q [0:(1<<ADDR_BITS)-1];

    // Single write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_en_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end else if (cpu_we_i) begin
            mem_q[cpu_addr_i] <= cpu_wdata_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/moonbase_ext_bus_responder.sv
// Responder end of the moonbase 8-bit CPU multiplexed nibble bus.
// Assembles a 12-bit address from two 6-bit strobes, serves memory nibbles
// and device read bits back to the CPU, and commits nibble-pair writes to
// the byte memory and/or a device port. Protocol violations set a sticky err.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   bus_out[7:0]        CPU io_out
//   bus_in[5:0]         to CPU io_in[7:2]: {dev_rd_data, memory nibble}
//   dev_addr[11:0]      latched address
//   dev_rd_data[1:0]    device read bits (passed through)
//   dev_wr_valid        one-cycle device write pulse
//   dev_wr_data[7:0]    assembled device write byte
//   ld_en/ld_addr/ld_data  program preload port
//   err                 sticky protocol-error flag
// Handshake: there is no back-pressure; every bus cycle is consumed on the
// clock edge that ends it, and dev_wr_valid is a pure one-cycle strobe.
module moonbase_ext_bus_responder
    import moonbase_bus_pkg::*;
#(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           bus_out,
    output logic [5:0]           bus_in,
    output logic [ADDR_W-1:0]    dev_addr,
    input  logic [1:0]           dev_rd_data,
    output logic                 dev_wr_valid,
    output logic [7:0]           dev_wr_data,
    input  logic                 ld_en,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [7:0]           ld_data,
    output logic                 err
);

    bus_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HALF_W-1:0]   lo6_q, lo6_d;
    logic [3:0]          hold_hi_q, hold_hi_d;
    logic                tgt_ram_q, tgt_ram_d;
    logic                tgt_dev_q, tgt_dev_d;
    logic                err_q, err_d;
    logic                dev_wr_valid_q;
    logic [7:0]          dev_wr_data_q;

    logic                stb, nib, wram_n, wdev_n, is_wr;
    logic                cpu_ram_we, dev_commit;
    logic [7:0]          wr_byte;
    logic [7:0]          rd_byte;

    assign stb     = bus_out[STB];
    assign nib     = bus_out[NIB];
    assign wram_n  = bus_out[WRAM_N];
    assign wdev_n  = bus_out[WDEV_N];
    assign is_wr   = !stb && !(wram_n && wdev_n);
    assign wr_byte = {hold_hi_q, bus_out[3:0]};

    always_comb begin
        state_d    = ST_IDLE;
        addr_d     = addr_q;
        lo6_d      = lo6_q;
        hold_hi_d  = hold_hi_q;
        tgt_ram_d  = tgt_ram_q;
        tgt_dev_d  = tgt_dev_q;
        err_d      = err_q;
        cpu_ram_we = 1'b0;
        dev_commit = 1'b0;

        if (stb) begin
            // An address cycle while a write is half done abandons that write.
            if (state_q == ST_WR_HI) err_d = 1'b1;
            if (!nib) begin
                lo6_d   = bus_out[HALF_W-1:0];
                state_d = ST_ADR_LO;
            end else begin
                // Unpaired high strobe still loads, using whatever lo6 holds.
                if (state_q != ST_ADR_LO) err_d = 1'b1;
                addr_d = {bus_out[HALF_W-1:0], lo6_q};
            end
        end else if (is_wr) begin
            if (!wram_n && !wdev_n) err_d = 1'b1;
            if (!nib) begin
                hold_hi_d = bus_out[3:0];
                tgt_ram_d = !wram_n;
                tgt_dev_d = !wdev_n;
                state_d   = ST_WR_HI;
            end else if (state_q == ST_WR_HI && tgt_ram_q == !wram_n && tgt_dev_q == !wdev_n) begin
                cpu_ram_we = tgt_ram_q;
                dev_commit = tgt_dev_q;
                // The loader owns the single write port this cycle.
                if (tgt_ram_q && ld_en) err_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == ST_WR_HI) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            lo6_q          <= '0;
            hold_hi_q      <= '0;
            tgt_ram_q      <= 1'b0;
            tgt_dev_q      <= 1'b0;
            err_q          <= 1'b0;
            dev_wr_valid_q <= 1'b0;
            dev_wr_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            lo6_q          <= lo6_d;
            hold_hi_q      <= hold_hi_d;
            tgt_ram_q      <= tgt_ram_d;
            tgt_dev_q      <= tgt_dev_d;
            err_q          <= err_d;
            dev_wr_valid_q <= dev_commit;
            if (dev_commit) dev_wr_data_q <= wr_byte;
        end
    end

    moonbase_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk         (clk),
        .cpu_we_i    (cpu_ram_we && !reset),
        .cpu_addr_i  (addr_q[ADDR_BITS-1:0]),
        .cpu_wdata_i (wr_byte),
        .ld_en_i     (ld_en),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data),
        .rd_addr_i   (addr_q[ADDR_BITS-1:0]),
        .rd_data_o   (rd_byte)
    );

    // nib selects the nibble: 0 -> high, 1 -> low.
    assign bus_in       = {dev_rd_data, nib ? rd_byte[3:0] : rd_byte[7:4]};
    assign dev_addr     = addr_q;
    assign dev_wr_valid = dev_wr_valid_q;
    assign dev_wr_data  = dev_wr_data_q;
    assign err          = err_q;

endmodule
